// File: rtl/mul_div_controller.sv
// ALU operation decoder plus an iterative RV32M-style multiply/divide unit.
// One M op is handled at a time; the pipeline is held via stall until the result strobes.
module mul_div_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic [3:0]       Operation,
  output logic             stall,
  output logic [WIDTH-1:0] md_result,
  output logic             md_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_srcA;
  logic [WIDTH-1:0]   r_mdResult;
  logic [2:0]         r_f3;
  logic [CW-1:0]      r_cnt;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;

  logic               w_mReq;
  logic               w_accept;
  logic               w_lastStep;
  logic               w_doneOk;
  logic               w_aSigned;
  logic               w_bSigned;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH+1:0]   w_trial;
  logic [2*WIDTH-1:0] w_mulStep;
  logic [2*WIDTH-1:0] w_divStep;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fixResult;

  assign w_mReq     = valid_in && (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign w_accept   = (r_state == IDLE) && w_mReq && !flush;
  assign w_lastStep = (r_cnt == CW'(WIDTH - 1));
  assign w_doneOk   = (r_state == DONE) && !flush;

  always_comb begin
    Operation = 4'b0000;
    case (ALUOp)
      2'b00: Operation = 4'b0010;
      2'b11: Operation = 4'b1010;
      2'b01: begin
        case (Funct3)
          3'b000:  Operation = 4'b1000;
          3'b100:  Operation = 4'b1011;
          3'b101:  Operation = 4'b1100;
          default: Operation = 4'b0000;
        endcase
      end
      2'b10: begin
        if (Funct7 == 7'b0000000) begin
          case (Funct3)
            3'b000:  Operation = 4'b0010;
            3'b001:  Operation = 4'b0110;
            3'b010:  Operation = 4'b1110;
            3'b100:  Operation = 4'b0100;
            3'b101:  Operation = 4'b0101;
            3'b110:  Operation = 4'b0001;
            3'b111:  Operation = 4'b0000;
            default: Operation = 4'b0000;
          endcase
        end else if (Funct7 == 7'b0100000) begin
          case (Funct3)
            3'b000:  Operation = 4'b0011;
            3'b101:  Operation = 4'b0111;
            default: Operation = 4'b0000;
          endcase
        end
      end
      default: Operation = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = CALC;
      CALC: begin
        if (flush)           w_nextState = IDLE;
        else if (w_lastStep) w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    stall     = w_mReq && (r_state != DONE);
    md_valid  = w_doneOk;
    md_result = w_doneOk ? w_fixResult : r_mdResult;
  end

  // Divides use sign on F3[0]==0; MUL low half is sign-agnostic so it runs unsigned.
  always_comb begin
    if (Funct3[2]) begin
      w_aSigned = !Funct3[0];
      w_bSigned = !Funct3[0];
    end else begin
      w_aSigned = (Funct3 == 3'b001) || (Funct3 == 3'b010);
      w_bSigned = (Funct3 == 3'b001);
    end
    w_aNeg = w_aSigned && SrcA[WIDTH-1];
    w_bNeg = w_bSigned && SrcB[WIDTH-1];
    w_aMag = w_aNeg ? -SrcA : SrcA;
    w_bMag = w_bNeg ? -SrcB : SrcB;
  end

  // r_acc = {high, low}: multiplier or dividend enters low and shifts out as the result forms.
  always_comb begin
    w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_divisor} : '0);
    w_mulStep = {w_mulSum, r_acc[WIDTH-1:1]};
    w_trial   = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_divisor};
    w_divStep = w_trial[WIDTH+1] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                 : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_divisor <= '0;
      r_srcA    <= '0;
      r_f3      <= '0;
      r_cnt     <= '0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else if (w_accept) begin
      r_acc     <= {{WIDTH{1'b0}}, w_aMag};
      r_divisor <= w_bMag;
      r_srcA    <= SrcA;
      r_f3      <= Funct3;
      r_cnt     <= '0;
      r_negRes  <= w_aNeg ^ w_bNeg;
      r_negRem  <= w_aNeg;
      r_divZero <= (SrcB == '0);
    end else if (r_state == CALC) begin
      r_acc <= r_f3[2] ? w_divStep : w_mulStep;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Signed overflow (MIN / -1) falls out of the magnitude path; only divide-by-zero needs overriding.
  always_comb begin
    w_prod      = r_negRes ? -r_acc : r_acc;
    w_quo       = r_divZero ? '1 : (r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    w_rem       = r_divZero ? r_srcA
                            : (r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH]);
    w_fixResult = '0;
    case (r_f3)
      3'b000:                 w_fixResult = w_prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fixResult = w_prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fixResult = w_quo;
      3'b110, 3'b111:         w_fixResult = w_rem;
      default:                w_fixResult = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_mdResult <= '0;
    else if (w_doneOk) r_mdResult <= w_fixResult;
  end

endmodule

// File: tb/tb_mul_div_controller.sv
// Random + directed bench for mul_div_controller: results are queued at issue
// and compared by an independent monitor whenever md_valid strobes.
module tb_mul_div_controller;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        ALUOp;
  logic [6:0]        Funct7;
  logic [2:0]        Funct3;
  logic              valid_in;
  logic [WIDTH-1:0]  SrcA;
  logic [WIDTH-1:0]  SrcB;
  logic              flush;
  logic [3:0]        Operation;
  logic              stall;
  logic [WIDTH-1:0]  md_result;
  logic              md_valid;

  int                errCount = 0;
  int                checkCount = 0;
  logic [31:0]       expQ[$];
  logic [31:0]       expVal;

  always #5 clk = ~clk;

  mul_div_controller #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .valid_in(valid_in), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
    .Operation(Operation), .stall(stall), .md_result(md_result), .md_valid(md_valid)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] refMD(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] qa, qb, sq;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    sub = ub;
    qa = a;
    qb = b;
    case (f3)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb;  return p[63:32]; end
      3'd2: begin p = sa * sub; return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      default: begin
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
          sq = f3[1] ? (qa % qb) : (qa / qb);
          return sq;
        end
        return f3[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic logic [3:0] refOperation(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b11) return 4'b1010;
    if (op == 2'b01) begin
      if (f3 == 3'b000) return 4'b1000;
      if (f3 == 3'b100) return 4'b1011;
      if (f3 == 3'b101) return 4'b1100;
      return 4'b0000;
    end
    if (f7 == 7'h00) begin
      case (f3)
        3'b000: return 4'b0010;
        3'b001: return 4'b0110;
        3'b010: return 4'b1110;
        3'b100: return 4'b0100;
        3'b101: return 4'b0101;
        3'b110: return 4'b0001;
        default: return 4'b0000;
      endcase
    end
    if (f7 == 7'h20 && f3 == 3'b000) return 4'b0011;
    if (f7 == 7'h20 && f3 == 3'b101) return 4'b0111;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one M op (call in IDLE, before the negedge); returns just after the edge leaving DONE.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int  stallCycles = 0;
    bit  done = 0;
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3;
    SrcA = a; SrcB = b; valid_in = 1'b1; flush = 1'b0;
    expQ.push_back(refMD(f3, a, b));
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        stallCycles++;
        if (stallCycles == 3) begin
          SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
        end
      end else begin
        done = 1;
        checkOutput("mdValidAtDone", 64'(md_valid), 64'd1);
      end
    end
    checkOutput("stallCycles", 64'(stallCycles), 64'(WIDTH + 1));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  always @(negedge clk) begin
    if (md_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedMdValid", 64'(md_valid), 64'd0);
      end else begin
        expVal = expQ.pop_front();
        checkOutput("mdResult", 64'(md_result), 64'(expVal));
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0;
    ALUOp = 2'b00; Funct7 = 7'd0; Funct3 = 3'd0; SrcA = '0; SrcB = '0;
    #12;
    checkOutput("resetMdValid", 64'(md_valid), 64'd0);
    checkOutput("resetMdResult", 64'(md_result), 64'd0);
    checkOutput("resetStallIdle", 64'(stall), 64'd0);
    checkOutput("resetOperation", 64'(Operation), 64'b0010);
    valid_in = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001;
    #1;
    checkOutput("resetStallMReq", 64'(stall), 64'd1);
    checkOutput("resetOpMReq", 64'(Operation), 64'd0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    ALUOp = 2'b10; Funct7 = 7'h20; Funct3 = 3'b101; #1;
    checkOutput("opSRA", 64'(Operation), 64'b0111);
    checkOutput("stallSRA", 64'(stall), 64'd0);
    ALUOp = 2'b01; Funct3 = 3'b100; #1;
    checkOutput("opBLT", 64'(Operation), 64'b1011);

    // flush held high keeps any m_req from being accepted during the sweep
    flush = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ALUOp = 2'($urandom);
      case ($urandom_range(0, 3))
        0: Funct7 = 7'h00;
        1: Funct7 = 7'h20;
        2: Funct7 = 7'h01;
        default: Funct7 = 7'($urandom);
      endcase
      Funct3 = 3'($urandom);
      valid_in = 1'($urandom);
      #2;
      checkOutput("opSweep", 64'(Operation), 64'(refOperation(ALUOp, Funct7, Funct3)));
      checkOutput("stallSweep", 64'(stall), 64'(valid_in && ALUOp == 2'b10 && Funct7 == 7'h01));
    end
    valid_in = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(3'b100, 32'd100, 32'd0);
    applyStimulus(3'b110, 32'd100, 32'd0);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(3'($urandom), randOperand(), randOperand());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Flush a DIVU in its 10th CALC cycle, then hold a MUL under flush before releasing it.
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b101;
    SrcA = 32'd1000; SrcB = 32'd7; valid_in = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    checkOutput("stallBeforeFlush", 64'(stall), 64'd1);
    @(posedge clk); #1;
    Funct3 = 3'b000; SrcA = 32'd12; SrcB = 32'd13;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(3'b000, 32'd12, 32'd13);

    applyStimulus(3'b000, 32'd5, 32'd9);
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b000;
    SrcA = 32'hDEAD_BEEF; SrcB = 32'd3; valid_in = 1'b1;
    repeat (12) @(posedge clk);
    #3;
    checkOutput("mdResultHeld", 64'(md_result), 64'd45);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstMdValid", 64'(md_valid), 64'd0);
    checkOutput("asyncRstMdResult", 64'(md_result), 64'd0);
    checkOutput("asyncRstStall", 64'(stall), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(3'b000, 32'hDEAD_BEEF, 32'd3);
    applyStimulus(3'b001, 32'hFFFF_FFF0, 32'd5);

    repeat (3) @(posedge clk);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mul_div_controller.md
MUL_DIV_CONTROLLER -- requirements
Module: mul_div_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the datapath width in bits; legal values are even and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port ALUOp, input, 2 bits: 00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-005 SHALL have ports Funct7 (7 bits) and Funct3 (3 bits), inputs: instruction bits 31:25 and 14:12.
REQ-006 SHALL have port valid_in, input, 1 bit: the decoded instruction is live this cycle.
REQ-007 SHALL have ports SrcA and SrcB, inputs, WIDTH bits each: the operands.
REQ-008 SHALL have port flush, input, 1 bit: kill any in-flight multiply/divide.
REQ-009 SHALL have port Operation, output, 4 bits: the ALU operation select.
REQ-010 SHALL have port stall, output, 1 bit: hold the pipeline.
REQ-011 SHALL have ports md_result (WIDTH bits) and md_valid (1 bit), outputs: the M-extension result and its strobe.

Function
REQ-012 m_req SHALL be defined as valid_in && ALUOp==10 && Funct7==0000001.
REQ-013 Operation SHALL be combinational and depend on ALUOp/Funct3/Funct7 only.
- ALUOp 00 gives 0010 (ADD).
- ALUOp 11 gives 1010.
- Branch: F3 000 gives 1000, F3 100 gives 1011, F3 101 gives 1100, any other F3 gives 0000.
- ALUOp 10, F7 0000000: F3 000 ADD 0010, F3 001 SLL 0110, F3 010 SLT 1110, F3 100 XOR 0100, F3 101 SRL 0101, F3 110 OR 0001, F3 111 AND 0000.
- ALUOp 10, F7 0100000: F3 000 SUB 0011, F3 101 SRA 0111.
- Any other combination, including m_req, gives 0000.
REQ-014 The FSM SHALL have three states, IDLE, CALC and DONE, with these transitions:
- IDLE to CALC when m_req && !flush.
- CALC to DONE after exactly WIDTH cycles, counted by a log2(WIDTH)+1-bit counter.
- DONE to IDLE unconditionally.
REQ-015 Operands and Funct3 SHALL be latched on the IDLE to CALC edge; input changes during CALC SHALL be ignored.
REQ-016 stall SHALL equal m_req && state!=DONE, combinationally.
- With WIDTH=32, stall is high for 33 consecutive cycles: accept cycle plus CALC.
REQ-017 md_valid SHALL be high for exactly the one cycle spent in DONE; md_result SHALL hold its value until the next DONE.
REQ-018 Multiply SHALL be iterative shift-add over 2*WIDTH-bit magnitudes, with signs fixed up in DONE.
- Funct3 000 MUL: low WIDTH bits.
- Funct3 001 MULH: signed x signed, high WIDTH bits.
- Funct3 010 MULHSU: signed x unsigned, high WIDTH bits.
- Funct3 011 MULHU: unsigned x unsigned, high WIDTH bits.
REQ-019 Divide SHALL be restoring, one quotient bit per cycle.
- Funct3 100 DIV and 110 REM are signed; 101 DIVU and 111 REMU are unsigned.
- The remainder takes the sign of the dividend.
REQ-020 Divide by zero SHALL complete with the same latency as a normal divide.
- Quotient is all-ones; remainder is SrcA.
REQ-021 Signed overflow (SrcA = most negative value, SrcB = -1) SHALL complete with the same latency.
- Quotient is the most negative value; remainder is 0.
REQ-022 flush while in CALC or DONE SHALL force IDLE on the next edge and suppress md_valid.
- flush in IDLE SHALL block acceptance.
REQ-023 Back-to-back M ops SHALL work: the cycle after DONE sits in IDLE, where a new m_req is accepted.
- The old instruction has left the stage because stall was low during DONE.

Reset
REQ-024 rst_n low SHALL immediately force, regardless of clk:
- state IDLE, counter 0, internal registers 0;
- md_result 0 and md_valid 0.
REQ-025 Operation and stall SHALL stay combinational during reset.
- stall equals m_req, since state is IDLE.
REQ-026 Deasserting rst_n mid-operation SHALL NOT resume the aborted operation; a still-present m_req is re-accepted from IDLE.

Verification
REQ-027 ALUOp=10, F3=101, F7=0100000 -> Operation=0111, stall=0; ALUOp=01, F3=100 -> 1011.
REQ-028 WIDTH=32, MUL 7 x 0xFFFFFFFD -> stall high 33 cycles, then md_valid=1 with md_result=0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 DIV 100/0 -> 0xFFFFFFFF; REM 100%0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM -> 0; REM -7%2 -> 0xFFFFFFFF.
REQ-030 DIVU issued, flush pulsed in CALC cycle 10 -> IDLE next cycle, md_valid never asserts, a following MUL completes normally.
REQ-031 rst_n pulsed low mid-CALC asynchronously -> md_valid=0 and md_result=0 immediately; after release, the held MUL restarts and completes in 33 cycles.
